// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage: arbitrates
// exceptions vs. interrupts, records SR/Cause/EPC and serves mfc0/mtc0/eret.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID = 32'h2022_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCM,
  input  logic        ValidM,
  input  logic        ExcOccurM,
  input  logic [4:0]  ExcCodeM,
  input  logic        ExcBDM,
  input  logic [5:0]  HWInt,
  input  logic        WeCP0,
  input  logic        EretM,
  input  logic [4:0]  RAddr,
  input  logic [4:0]  WAddr,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IntReq,
  output logic [31:0] EPCOut
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [29:0] epc_q, epc_d;

  logic        int_irq;
  logic        exc_acc;
  logic        int_req;
  logic [31:0] pc_sel;
  logic        unused_pc;

  // Interrupt decision uses the registered IP so HWInt has one cycle of latency.
  assign int_irq   = (|(cause_ip_q & sr_im_q)) & sr_ie_q & ~sr_exl_q & ValidM;
  assign exc_acc   = ExcOccurM & ValidM & ~sr_exl_q;
  assign int_req   = (int_irq | exc_acc) & ~reset;
  assign IntReq    = int_req;

  assign pc_sel    = ExcBDM ? (PCM - 32'd4) : PCM;
  assign unused_pc = ^pc_sel[1:0];

  assign EPCOut    = reset ? 32'd0 : {epc_q, 2'b00};

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (int_req) begin
      // The excepting instruction is cancelled, so any mtc0/eret it carries is dropped.
      sr_exl_d    = 1'b1;
      cause_bd_d  = ExcBDM;
      cause_exc_d = int_irq ? 5'd0 : ExcCodeM;
      epc_d       = pc_sel[31:2];
    end else begin
      if (WeCP0) begin
        case (WAddr)
          ADDR_SR: begin
            sr_im_d  = DIn[15:10];
            sr_exl_d = DIn[1];
            sr_ie_d  = DIn[0];
          end
          ADDR_EPC: epc_d = DIn[31:2];
          default: ;
        endcase
      end
      if (EretM && sr_exl_q) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 30'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= HWInt;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (RAddr)
      ADDR_SR:    DOut = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
      ADDR_CAUSE: DOut = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'b00};
      ADDR_EPC:   DOut = {epc_q, 2'b00};
      ADDR_PRID:  DOut = PRID;
      default:    DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: linear steps with hand-computed expectations.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCM;
  logic        ValidM;
  logic        ExcOccurM;
  logic [4:0]  ExcCodeM;
  logic        ExcBDM;
  logic [5:0]  HWInt;
  logic        WeCP0;
  logic        EretM;
  logic [4:0]  RAddr;
  logic [4:0]  WAddr;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IntReq;
  logic [31:0] EPCOut;

  int total = 0;
  int bad   = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .PCM(PCM), .ValidM(ValidM),
    .ExcOccurM(ExcOccurM), .ExcCodeM(ExcCodeM), .ExcBDM(ExcBDM),
    .HWInt(HWInt), .WeCP0(WeCP0), .EretM(EretM), .RAddr(RAddr),
    .WAddr(WAddr), .DIn(DIn), .DOut(DOut), .IntReq(IntReq), .EPCOut(EPCOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("check %s: got %h", tag, obs);
    end else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    RAddr = a;
    #1;
    chk(tag, DOut, exp);
  endtask

  task automatic idle();
    ValidM = 0; ExcOccurM = 0; ExcCodeM = 0; ExcBDM = 0;
    WeCP0 = 0; EretM = 0; WAddr = 0; DIn = 0;
  endtask

  initial begin
    reset = 1; PCM = 0; HWInt = 0; RAddr = 0;
    idle();
    #1;
    chk("irq_in_reset0", {31'd0, IntReq}, 32'd0);
    chk("epc_in_reset0", EPCOut, 32'd0);
    tick(); tick();
    // Reset overrides active inputs.
    ValidM = 1; ExcOccurM = 1; ExcCodeM = 5'd10; PCM = 32'h100;
    #1;
    chk("irq_reset_override", {31'd0, IntReq}, 32'd0);
    tick();
    idle();
    reset = 0;
    #1;
    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc", 32'd0);
    rd(5'd15, "rst_prid", 32'h2022_0001);
    chk("rst_irq", {31'd0, IntReq}, 32'd0);

    // Synchronous exception.
    PCM = 32'h3010; ValidM = 1; ExcOccurM = 1; ExcCodeM = 5'd10;
    #1;
    chk("exc_irq", {31'd0, IntReq}, 32'd1);
    tick();
    idle();
    rd(5'd14, "exc_epc", 32'h3010);
    rd(5'd13, "exc_cause", 32'h0000_0028);
    rd(5'd12, "exc_sr", 32'h0000_0002);
    chk("exc_epcout", EPCOut, 32'h3010);

    // Exception while EXL=1 is ignored.
    PCM = 32'h5000; ValidM = 1; ExcOccurM = 1; ExcCodeM = 5'd12;
    #1;
    chk("exl_block_irq", {31'd0, IntReq}, 32'd0);
    tick();
    idle();
    rd(5'd14, "exl_block_epc", 32'h3010);

    // eret clears EXL.
    ValidM = 1; EretM = 1;
    #1;
    chk("eret_epcout", EPCOut, 32'h3010);
    tick();
    idle();
    rd(5'd12, "eret_sr", 32'd0);

    // Delay-slot exception.
    PCM = 32'h3014; ValidM = 1; ExcOccurM = 1; ExcBDM = 1; ExcCodeM = 5'd4;
    #1;
    chk("bd_irq", {31'd0, IntReq}, 32'd1);
    tick();
    idle();
    rd(5'd14, "bd_epc", 32'h3010);
    rd(5'd13, "bd_cause", 32'h8000_0010);

    // Enable IM0+IE, clearing EXL.
    ValidM = 1; WeCP0 = 1; WAddr = 5'd12; DIn = 32'h0000_0401;
    tick();
    idle();
    rd(5'd12, "sr_write", 32'h0000_0401);

    // Interrupt: one-cycle latency through IP.
    HWInt = 6'b000001; ValidM = 1;
    #1;
    chk("int_latency0", {31'd0, IntReq}, 32'd0);
    tick();
    // Interrupt + exception + mtc0 EPC on the same instruction.
    PCM = 32'h4000; ExcOccurM = 1; ExcCodeM = 5'd12;
    WeCP0 = 1; WAddr = 5'd14; DIn = 32'hDEAD_BEEF;
    #1;
    chk("int_irq", {31'd0, IntReq}, 32'd1);
    tick();
    idle();
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd14, "int_epc_no_mtc0", 32'h4000);
    rd(5'd12, "int_sr", 32'h0000_0403);

    // IM=0, IE=1: masked.
    ValidM = 1; WeCP0 = 1; WAddr = 5'd12; DIn = 32'h0000_0001;
    tick();
    idle();
    ValidM = 1;
    #1;
    chk("mask_im_irq", {31'd0, IntReq}, 32'd0);
    rd(5'd13, "mask_ip", 32'h0000_0400);
    // IM=1, IE=0: masked.
    WeCP0 = 1; WAddr = 5'd12; DIn = 32'h0000_0400;
    tick();
    idle();
    ValidM = 1;
    #1;
    chk("mask_ie_irq", {31'd0, IntReq}, 32'd0);

    // Re-enable, interrupt deferred across bubbles.
    WeCP0 = 1; WAddr = 5'd12; DIn = 32'h0000_0401;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("defer_bubble", {31'd0, IntReq}, 32'd0);
      tick();
    end
    ValidM = 1; PCM = 32'h6000;
    #1;
    chk("defer_fire", {31'd0, IntReq}, 32'd1);
    tick();
    idle();
    rd(5'd14, "defer_epc", 32'h6000);
    rd(5'd13, "defer_cause", 32'h0000_0400);

    // eret with interrupt still held: fires on next valid instruction.
    ValidM = 1; EretM = 1;
    #1;
    chk("eret2_irq", {31'd0, IntReq}, 32'd0);
    chk("eret2_epcout", EPCOut, 32'h6000);
    tick();
    idle();
    ValidM = 1; PCM = 32'h7000;
    #1;
    chk("post_eret_irq", {31'd0, IntReq}, 32'd1);
    tick();
    idle();
    rd(5'd12, "post_eret_sr", 32'h0000_0403);

    // mtc0 EPC: no bypass to DOut, EPCOut updates next cycle.
    ValidM = 1; WeCP0 = 1; WAddr = 5'd14; DIn = 32'h1234_5677;
    rd(5'd14, "epc_nobypass", 32'h7000);
    chk("epcout_pre", EPCOut, 32'h7000);
    tick();
    chk("epcout_post", EPCOut, 32'h1234_5674);
    // Writes to Cause and unmapped addresses are ignored.
    WAddr = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    WAddr = 5'd5;
    tick();
    idle();
    rd(5'd13, "cause_ro", 32'h0000_0400);
    rd(5'd5, "unmapped", 32'd0);

    // Reset mid-run.
    reset = 1; HWInt = 0;
    #1;
    chk("reset2_epcout", EPCOut, 32'd0);
    tick();
    reset = 0;
    rd(5'd12, "reset2_sr", 32'd0);
    rd(5'd13, "reset2_cause", 32'd0);
    rd(5'd14, "reset2_epc", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
